// File: rtl/stream_mux_n.sv
// Packet-granular N-input stream multiplexer: whole packets from N_IN sources merged onto one
// registered output stream, with per-packet metadata/source tag and per-input packet counters.
module stream_mux_n #(
  parameter int N_IN      = 4,
  parameter int DW        = 512,
  parameter int EW        = 6,
  parameter int MW        = 128,
  parameter int PRIO_MODE = 0,
  parameter int CW        = $clog2(N_IN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_IN*DW-1:0]   in_data,
  input  logic [N_IN-1:0]      in_valid,
  input  logic [N_IN-1:0]      in_sop,
  input  logic [N_IN-1:0]      in_eop,
  input  logic [N_IN*EW-1:0]   in_empty,
  input  logic [N_IN*MW-1:0]   in_meta,
  output logic [N_IN-1:0]      in_ready,
  output logic [DW-1:0]        out_data,
  output logic                 out_valid,
  output logic                 out_sop,
  output logic                 out_eop,
  output logic [EW-1:0]        out_empty,
  output logic [MW-1:0]        out_meta,
  output logic [CW-1:0]        out_chan,
  input  logic                 out_ready,
  input  logic                 out_almost_full,
  output logic [N_IN*32-1:0]   pkt_cnt,
  output logic [31:0]          drop_cnt
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state;
  logic [CW-1:0]   sel;
  logic [CW-1:0]   rr_ptr;
  logic [31:0]     pkt_cnt_r [N_IN];

  logic            can_load;
  logic [N_IN-1:0] cand;
  logic [N_IN-1:0] orphan;
  logic            grant_vld;
  logic [CW-1:0]   grant;
  logic            orphan_vld;
  logic [CW-1:0]   orphan_idx;
  logic [CW-1:0]   ld_idx;
  logic            take;
  logic [DW-1:0]   src_data;
  logic            src_eop;
  logic            src_sop;
  logic [EW-1:0]   src_empty;
  logic [MW-1:0]   src_meta;

  assign can_load = !out_valid || out_ready;
  assign cand     = in_valid & in_sop;
  assign orphan   = in_valid & ~in_sop;

  // Grant selection; round-robin scans upward from rr_ptr, fixed priority keeps the lowest index.
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    if (PRIO_MODE == 1) begin
      for (int i = N_IN - 1; i >= 0; i--) begin
        if (cand[i]) begin
          grant_vld = 1'b1;
          grant     = CW'(i);
        end
      end
    end else begin
      for (int k = 0; k < N_IN; k++) begin
        if (!grant_vld && cand[(int'(rr_ptr) + k) % N_IN]) begin
          grant_vld = 1'b1;
          grant     = CW'((int'(rr_ptr) + k) % N_IN);
        end
      end
    end
  end

  always_comb begin
    orphan_vld = 1'b0;
    orphan_idx = '0;
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (orphan[i]) begin
        orphan_vld = 1'b1;
        orphan_idx = CW'(i);
      end
    end
  end

  assign ld_idx    = (state == IDLE) ? grant : sel;
  assign src_data  = in_data[ld_idx*DW +: DW];
  assign src_sop   = in_sop[ld_idx];
  assign src_eop   = in_eop[ld_idx];
  assign src_empty = in_empty[ld_idx*EW +: EW];
  assign src_meta  = in_meta[ld_idx*MW +: MW];
  assign take      = (state == IDLE) ? (grant_vld && !out_almost_full && can_load)
                                     : (in_valid[sel] && can_load);

  // Orphans are swallowed in IDLE even under almost_full; in_ready is forced low during reset.
  always_comb begin
    in_ready = '0;
    if (!rst) begin
      if (state == IDLE) begin
        if (orphan_vld) in_ready[orphan_idx] = 1'b1;
        if (grant_vld && !out_almost_full) in_ready[grant] = can_load;
      end else begin
        in_ready[sel] = can_load;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= '0;
      rr_ptr    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_empty <= '0;
      out_meta  <= '0;
      out_chan  <= '0;
      drop_cnt  <= '0;
      for (int i = 0; i < N_IN; i++) pkt_cnt_r[i] <= '0;
    end else begin
      if (can_load) begin
        out_valid <= take;
        if (take) begin
          out_data  <= src_data;
          out_sop   <= src_sop;
          out_eop   <= src_eop;
          out_empty <= src_empty;
        end
      end
      if (state == IDLE && take) begin
        out_meta <= src_meta;
        out_chan <= grant;
      end
      if (take && src_eop) begin
        pkt_cnt_r[ld_idx] <= pkt_cnt_r[ld_idx] + 32'd1;
        state             <= IDLE;
        if (PRIO_MODE == 0)
          rr_ptr <= (int'(ld_idx) == N_IN - 1) ? '0 : ld_idx + CW'(1);
      end else if (take && state == IDLE) begin
        state <= LOCKED;
        sel   <= grant;
      end
      if (state == IDLE && orphan_vld) drop_cnt <= drop_cnt + 32'd1;
    end
  end

  for (genvar g = 0; g < N_IN; g++) begin : g_cnt
    assign pkt_cnt[g*32 +: 32] = pkt_cnt_r[g];
  end

endmodule

// File: doc/stream_mux_n.md
Name: stream_mux_n

Overview:
- Packet-granular N-input stream multiplexer with per-input metadata sideband and source tagging.
- Merges N_IN 512-bit packet streams onto one output stream.
- Whole packets are never interleaved; arbitration is round-robin or fixed-priority.
- Sits in front of the flow/reassembly pipeline; generalises the 2-input pkt/usr mux to N inputs and adds selectable arbitration and per-input counters.

Parameters:
N_IN, 4, number of input streams (2..16)
DW, 512, data width per flit
EW, 6, empty field width (log2(DW/8))
MW, 128, metadata width per packet
PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)
CW, $clog2(N_IN), width of out_chan

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_data  in  N_IN*DW  input flits, input i at [i*DW +: DW]
in_valid  in  N_IN  flit valid per input
in_sop  in  N_IN  start of packet
in_eop  in  N_IN  end of packet
in_empty  in  N_IN*EW  empty bytes on eop flit
in_meta  in  N_IN*MW  packet metadata, sampled on sop flit
in_ready  out  N_IN  flit accepted when in_valid & in_ready
out_data  out  DW  output flit
out_valid  out  1  output valid
out_sop  out  1  output start of packet
out_eop  out  1  output end of packet
out_empty  out  EW  output empty
out_meta  out  MW  metadata of current output packet
out_chan  out  CW  source input index of current output packet
out_ready  in  1  downstream accepts flit
out_almost_full  in  1  downstream asks that no new packet start
pkt_cnt  out  N_IN*32  packets forwarded per input
drop_cnt  out  32  orphan flits discarded

Behaviour:
- Single clock clk. Reset rst is asynchronous, active-high.
- Reset values: all outputs 0; state IDLE; rr_ptr 0; counters 0.
- Output stage: one register slot, so input-to-output latency is 1 cycle. The slot loads when can_load = !out_valid || out_ready. out_* are held stable while out_valid && !out_ready.
- States: IDLE and LOCKED(sel).
- IDLE:
  - Candidates are inputs with in_valid & in_sop.
  - If out_almost_full = 1, grant nothing and drive in_ready = 0, except for orphan flits (below).
  - Otherwise pick a grant g:
    - PRIO_MODE 0: first candidate at or after rr_ptr, modulo N_IN.
    - PRIO_MODE 1: lowest candidate index.
  - When can_load: in_ready[g] = 1 and the sop flit is loaded. out_meta and out_chan are latched from input g.
    - If the flit also has eop: stay IDLE and increment pkt_cnt[g].
    - Else go to LOCKED(g).
- Orphan flits (in_valid & !in_sop while IDLE): always accepted and discarded, in_ready = 1 regardless of almost_full; drop_cnt increments. At most one orphan per cycle, lowest index first.
- LOCKED(sel):
  - Only in_ready[sel] = can_load may be asserted; all other in_ready = 0.
  - out_almost_full is ignored.
  - A sop flit arriving on sel is forwarded unchanged; no recovery is attempted.
  - On the accepted eop: increment pkt_cnt[sel] and return to IDLE. In round-robin mode set rr_ptr = (sel+1) mod N_IN.
- Single-flit packets also advance rr_ptr.
- Back-to-back packets: the eop and the next granted sop may occupy consecutive output cycles; no bubble is required.
- out_meta and out_chan are constant from sop to eop of an output packet.
- Counters are 32-bit and wrap to 0 after 0xFFFFFFFF.
- Reset mid-packet: the in-flight packet is truncated (no eop emitted) and the state returns to IDLE.

Test Plan:
- N_IN=4, RR, all inputs offer 3-flit packets continuously, out_ready=1 -> output packet order 0,1,2,3,0,...; no interleaving; out_chan correct; 12 flits in 12 cycles; each pkt_cnt = 3 after 36 cycles.
- PRIO_MODE=1, inputs 1 and 3 always offering 2-flit packets -> only input 1 served; pkt_cnt[3] stays 0.
- out_almost_full=1 in IDLE with input 2 offering sop -> in_ready=0 and no out_valid. Assert almost_full mid-packet -> packet completes through eop.
- out_ready toggles 1010... during a 5-flit packet -> out_data/out_meta stable while stalled; all 5 flits delivered in order, then pkt_cnt=1.
- Orphan flit (valid, sop=0) on input 0 in IDLE -> accepted, not forwarded, drop_cnt=1. Single-flit sop&eop packets on 0 and 1 -> output 0 then 1 in consecutive cycles.
- rst pulsed during flit 2 of 4 -> all outputs 0 asynchronously. After release, the next sop on input 3 is granted with rr_ptr=0 ordering.
